riscv_data_bus: RTL and testbench



---
 rtl/riscv_data_bus.sv | 94 +++++++++
 tb/tb_riscv_data_bus.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_data_bus.sv
// riscv_data_bus: routes CPU word accesses to BRAM or MMIO registers with a fixed 2-cycle read latency
module riscv_data_bus #(
  parameter int BRAM_ADDR_WIDTH = 14,
  parameter int TX_FIFO_DEPTH = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [31:0]                bus_addr_in,
  input  logic [31:0]                bus_data_in,
  input  logic [3:0]                 bus_we_in,
  input  logic                       bus_re_in,
  output logic [31:0]                bus_data_out,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_addr_out,
  output logic [31:0]                bram_data_out,
  output logic [3:0]                 bram_we_out,
  input  logic [31:0]                bram_data_in,
  input  logic [15:0]                sw_in,
  output logic [15:0]                led_out,
  output logic [7:0]                 uart_tx_data_out,
  output logic                       uart_tx_valid_out,
  input  logic                       uart_tx_ready_in
);
  localparam int PW = $clog2(TX_FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic is_mmio, is_bram;
  logic [3:0] off;
  logic [63:0] cycle;
  logic [31:0] cyc_hi_snap, mmio_rd, mmio_q1, mmio_q2;
  logic [7:0] fifo [TX_FIFO_DEPTH];
  logic [7:0] stat;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic overflow, full, empty, pop, push, accept, ovf_set, ovf_clr, snap, led_wr;
  logic rd_bram1, rd_mmio1, rd_bram2, rd_mmio2;
  logic unused;
  assign unused = ^bus_addr_in[31:30];
  assign is_mmio = bus_addr_in[29];
  assign is_bram = !bus_addr_in[29] && bus_addr_in[28:BRAM_ADDR_WIDTH] == '0;
  assign off = bus_addr_in[3:0];
  assign bram_addr_out = bus_addr_in[BRAM_ADDR_WIDTH-1:0];
  assign bram_data_out = bus_data_in;
  assign bram_we_out = is_bram ? bus_we_in : 4'b0;
  assign full = count == CW'(TX_FIFO_DEPTH);
  assign empty = count == '0;
  assign pop = !empty && uart_tx_ready_in;
  assign push = is_mmio && off == 4'd4 && bus_we_in[0];
  // a push into a full FIFO still lands if the head leaves in the same cycle
  assign accept = push && (!full || pop);
  assign ovf_set = push && full && !pop;
  assign ovf_clr = is_mmio && off == 4'd5 && bus_we_in[0] && bus_data_in[2];
  assign snap = bus_re_in && is_mmio && off == 4'd2;
  assign led_wr = is_mmio && off == 4'd0;
  assign uart_tx_valid_out = !empty;
  assign uart_tx_data_out = fifo[rd_ptr];
  assign stat = {4'(count), 1'b0, overflow, empty, full};
  always_comb
    case (off)
      4'd0: mmio_rd = {16'h0, led_out};
      4'd1: mmio_rd = {16'h0, sw_in};
      4'd2: mmio_rd = cycle[31:0];
      4'd3: mmio_rd = cyc_hi_snap;
      4'd5: mmio_rd = {24'h0, stat};
      default: mmio_rd = '0;
    endcase
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      led_out <= '0;
      cycle <= '0;
      cyc_hi_snap <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      mmio_q1 <= '0;
      mmio_q2 <= '0;
      {rd_bram1, rd_mmio1, rd_bram2, rd_mmio2} <= '0;
    end else begin
      cycle <= cycle + 64'd1;
      if (snap) cyc_hi_snap <= cycle[63:32];
      if (led_wr && bus_we_in[0]) led_out[7:0] <= bus_data_in[7:0];
      if (led_wr && bus_we_in[1]) led_out[15:8] <= bus_data_in[15:8];
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      count <= count + CW'(accept) - CW'(pop);
      overflow <= ovf_set | (overflow & !ovf_clr);
      mmio_q1 <= mmio_rd;
      mmio_q2 <= mmio_q1;
      {rd_bram1, rd_mmio1} <= {bus_re_in && is_bram, bus_re_in && is_mmio};
      {rd_bram2, rd_mmio2} <= {rd_bram1, rd_mmio1};
    end
  always_ff @(posedge clk_in)
    if (accept) fifo[wr_ptr] <= bus_data_in[7:0];
  assign bus_data_out = rd_bram2 ? bram_data_in : rd_mmio2 ? mmio_q2 : '0;
endmodule

// File: tb/tb_riscv_data_bus.sv
// tb_riscv_data_bus: directed and random accesses checked against a queue-based model of the bus
module tb_riscv_data_bus;
  localparam int BW = 14;
  localparam int D = 4;
  logic clk_in = 1'b0, rst_in = 1'b1;
  logic [31:0] bus_addr_in = '0, bus_data_in = '0, bus_data_out, bram_data_out, bram_data_in = '0;
  logic [3:0] bus_we_in = '0, bram_we_out;
  logic bus_re_in = 1'b0, uart_tx_valid_out, uart_tx_ready_in = 1'b0;
  logic [BW-1:0] bram_addr_out;
  logic [15:0] sw_in = '0, led_out;
  logic [7:0] uart_tx_data_out;
  int checks = 0, failures = 0;

  riscv_data_bus #(.BRAM_ADDR_WIDTH(BW), .TX_FIFO_DEPTH(D)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .bus_addr_in(bus_addr_in), .bus_data_in(bus_data_in),
    .bus_we_in(bus_we_in), .bus_re_in(bus_re_in), .bus_data_out(bus_data_out),
    .bram_addr_out(bram_addr_out), .bram_data_out(bram_data_out), .bram_we_out(bram_we_out),
    .bram_data_in(bram_data_in), .sw_in(sw_in), .led_out(led_out),
    .uart_tx_data_out(uart_tx_data_out), .uart_tx_valid_out(uart_tx_valid_out),
    .uart_tx_ready_in(uart_tx_ready_in)
  );

  always #5 clk_in = ~clk_in;

  // external BRAM with 2-cycle read latency
  logic [31:0] ext_mem [2**BW];
  logic [31:0] bram_q;
  always @(posedge clk_in) begin
    bram_q <= ext_mem[bram_addr_out];
    bram_data_in <= bram_q;
    for (int i = 0; i < 4; i++)
      if (bram_we_out[i]) ext_mem[bram_addr_out][8*i+:8] <= bram_data_out[8*i+:8];
  end

  logic [31:0] ref_mem [2**BW];
  logic [15:0] m_led;
  logic [7:0] m_q [$];
  logic m_ovf;
  logic [63:0] m_cyc;
  logic [31:0] m_snap, e1, e2;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_led = '0; m_q.delete(); m_ovf = 1'b0; m_cyc = '0; m_snap = '0; e1 = '0; e2 = '0;
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w, input logic r, input logic rdy);
    logic [31:0] rv;
    logic mm, br, set;
    logic [3:0] off;
    bus_addr_in = a; bus_data_in = d; bus_we_in = w; bus_re_in = r; uart_tx_ready_in = rdy;
    sw_in = 16'($urandom);
    @(negedge clk_in);
    mm = a[29];
    br = !a[29] && a[28:BW] == '0;
    off = a[3:0];
    chk("rdata", bus_data_out, e2);
    chk("bram_we", bram_we_out, br ? w : 4'h0);
    chk("led", led_out, m_led);
    chk("tx_valid", uart_tx_valid_out, m_q.size() != 0);
    if (m_q.size() != 0) chk("tx_head", uart_tx_data_out, m_q[0]);
    rv = '0;
    if (r && br) rv = ref_mem[a[BW-1:0]];
    else if (r && mm)
      case (off)
        4'd0: rv = {16'h0, m_led};
        4'd1: rv = {16'h0, sw_in};
        4'd2: rv = m_cyc[31:0];
        4'd3: rv = m_snap;
        4'd5: rv = 32'(m_q.size() * 16 + (m_ovf ? 4 : 0) + (m_q.size() == 0 ? 2 : 0) + (m_q.size() == D ? 1 : 0));
        default: rv = '0;
      endcase
    e2 = e1;
    e1 = rv;
    if (r && mm && off == 4'd2) m_snap = m_cyc[63:32];
    if (br)
      for (int i = 0; i < 4; i++) if (w[i]) ref_mem[a[BW-1:0]][8*i+:8] = d[8*i+:8];
    if (mm && off == 4'd0) begin
      if (w[0]) m_led[7:0] = d[7:0];
      if (w[1]) m_led[15:8] = d[15:8];
    end
    if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
    set = 1'b0;
    if (mm && off == 4'd4 && w[0]) begin
      if (m_q.size() < D) m_q.push_back(d[7:0]);
      else set = 1'b1;
    end
    if (set) m_ovf = 1'b1;
    else if (mm && off == 4'd5 && w[0] && d[2]) m_ovf = 1'b0;
    m_cyc = m_cyc + 64'd1;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    step(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] a;
    int k;
    for (int i = 0; i < 2**BW; i++) ref_mem[i] = '0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    chk("reset_rdata", bus_data_out, 32'h0);
    chk("reset_led", led_out, 16'h0);
    chk("reset_valid", uart_tx_valid_out, 1'b0);
    for (int i = 0; i < 32; i++) step(32'(i), $urandom, 4'hF, 1'b0, 1'b0);
    step(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
    step(32'h10, 32'h0, 4'h0, 1'b1, 1'b0);
    idle();
    chk("bram_rd", bus_data_out, 32'hDEADBEEF);
    idle();
    chk("bram_rd_after", bus_data_out, 32'h0);
    step(32'h2000_0000, 32'h0000_A5C3, 4'b0001, 1'b0, 1'b0);
    chk("led_lo", led_out, 16'h00C3);
    step(32'h2000_0000, 32'h0000_A5C3, 4'b0010, 1'b0, 1'b0);
    chk("led_hi", led_out, 16'hA5C3);
    step(32'h2000_0000, 32'h0, 4'h0, 1'b1, 1'b0);
    idle();
    chk("led_rd", bus_data_out, 32'h0000_A5C3);
    step(32'h2000_0002, 32'h0, 4'h0, 1'b1, 1'b0);
    step(32'h2000_0003, 32'h0, 4'h0, 1'b1, 1'b0);
    idle();
    idle();
    for (int i = 1; i <= 5; i++) step(32'h2000_0004, 32'(i), 4'b0001, 1'b0, 1'b0);
    step(32'h2000_0005, 32'h0, 4'h0, 1'b1, 1'b0);
    idle();
    chk("stat_ovf_full", bus_data_out, 32'h45);
    for (int i = 1; i <= 4; i++) begin
      chk("tx_order", uart_tx_data_out, 8'(i));
      step(32'h0, 32'h0, 4'h0, 1'b0, 1'b1);
    end
    chk("tx_drained", uart_tx_valid_out, 1'b0);
    step(32'h2000_0005, 32'h4, 4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(32'h2000_0004, 32'h11 + 32'(i), 4'b0001, 1'b0, 1'b0);
    step(32'h2000_0004, 32'h15, 4'b0001, 1'b0, 1'b1);
    step(32'h2000_0005, 32'h0, 4'h0, 1'b1, 1'b0);
    idle();
    chk("stat_push_pop", bus_data_out, 32'h41);
    step(32'h2000_0004, 32'h16, 4'b0001, 1'b0, 1'b0);
    step(32'h2000_0005, 32'h0, 4'h0, 1'b1, 1'b0);
    idle();
    chk("stat_ovf_set", bus_data_out, 32'h45);
    step(32'h2000_0005, 32'h4, 4'b0001, 1'b0, 1'b0);
    step(32'h2000_0005, 32'h0, 4'h0, 1'b1, 1'b0);
    idle();
    chk("stat_ovf_clr", bus_data_out, 32'h41);
    step(32'h1000_0000, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0);
    idle();
    chk("unmapped_rd", bus_data_out, 32'h0);
    step(32'h10, 32'h0, 4'h0, 1'b1, 1'b0);
    step(32'h10, 32'h0, 4'h0, 1'b1, 1'b0);
    bus_addr_in = '0; bus_we_in = '0; bus_re_in = 1'b0;
    #1;
    rst_in = 1'b1;
    #1;
    chk("rst_async_rdata", bus_data_out, 32'h0);
    chk("rst_led", led_out, 16'h0);
    chk("rst_valid", uart_tx_valid_out, 1'b0);
    chk("rst_bram_we", bram_we_out, 4'h0);
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    chk("rst_rdata_late", bus_data_out, 32'h0);
    rst_in = 1'b0;
    model_reset();
    for (int n = 0; n < 600; n++) begin
      k = $urandom_range(0, 9);
      if (k < 4) a = $urandom_range(0, 31);
      else if (k < 8) a = 32'h2000_0000 | ($urandom & 32'h0FFF_FFF0) | 32'($urandom_range(0, 7));
      else if (k == 8) a = 32'h1000_0000 | 32'($urandom_range(0, 15));
      else a = 32'h8000_0010;
      step(a, $urandom, $urandom_range(0, 2) == 0 ? 4'($urandom) : 4'h0, 1'($urandom), 1'($urandom));
    end
    idle();
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
